// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM encodings and
// a counter-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Counter width for a slice index; never narrower than one bit.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// W-bit adder with carry in and carry out.
module full_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle N-bit adder: ripples one W-bit slice per cycle through a single
// full_adder, chaining the carry, with valid/ready on both sides.
module chunked_adder_seq
    import adder_pkg::*;
#(
    parameter int N = 1024,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         busy
);

    localparam int CHUNKS = N / W;
    localparam int CW     = cnt_width(CHUNKS);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  s_q, s_d;
    logic          c_out_q, c_out_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  a_slice [CHUNKS];
    logic [W-1:0]  b_slice [CHUNKS];
    logic [W-1:0]  slice_s;
    logic          slice_cout;
    logic          last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_slice
            assign a_slice[gi] = a_q[gi*W +: W];
            assign b_slice[gi] = b_q[gi*W +: W];
        end
    endgenerate

    full_adder #(.W(W)) u_slice_adder (
        .a     (a_slice[idx_q]),
        .b     (b_slice[idx_q]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_cout)
    );

    assign last_slice = (idx_q == CW'(CHUNKS - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < CHUNKS; k++) begin
                    if (idx_q == CW'(k)) s_d[k*W +: W] = slice_s;
                end
                carry_d = slice_cout;
                idx_d   = idx_q + CW'(1);
                if (last_slice) begin
                    c_out_d     = slice_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed checks of chunked_adder_seq at N=1024, W=32 with hand-computed sums.
module tb_chunked_adder_seq;

    localparam int N      = 1024;
    localparam int W      = 32;
    localparam int CHUNKS = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    chunked_adder_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        logic [N-1:0] diff;
        diff = obs ^ exp;
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed[63:0]=%h expected[63:0]=%h observed[N-1:N-64]=%h expected[N-1:N-64]=%h differing_bits=%0d",
                   tag, obs[63:0], exp[63:0], obs[N-1 -: 64], exp[N-1 -: 64], $countones(diff));
        end
    endtask

    // Present an operand pair, wait for the result, check it, then accept it.
    task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic tc, input logic [N-1:0] es, input logic ec);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
        chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        c_in = ~tc;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_int({tag, "_latency"}, lat, CHUNKS);
        chk_vec({tag, "_sum"}, s, es);
        chk_bit({tag, "_c_out"}, c_out, ec);
        $display("[TB] op %s latency=%0d c_out=%b s[63:0]=%h", tag, lat, c_out, s[63:0]);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_bit({tag, "_out_valid_cleared"}, out_valid, 1'b0);
        chk_bit({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    logic [N-1:0] ones;
    logic [N-1:0] exp_s;

    initial begin
        ones      = '1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_bit("reset_in_ready", in_ready, 1'b0);
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_vec("reset_s", s, '0);
        chk_bit("reset_c_out", c_out, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("post_reset_in_ready", in_ready, 1'b1);

        run_op("zero", '0, '0, 1'b0, '0, 1'b0);
        exp_s = '0; exp_s[0] = 1'b1;
        run_op("zero_cin", '0, '0, 1'b1, exp_s, 1'b0);
        exp_s = ones; exp_s[0] = 1'b0;
        run_op("ones_ones", ones, ones, 1'b0, exp_s, 1'b1);
        run_op("ones_ones_cin", ones, ones, 1'b1, ones, 1'b1);
        exp_s = '0; exp_s[32] = 1'b1;
        run_op("slice_carry", {{(N-32){1'b0}}, 32'hFFFF_FFFF}, {{(N-1){1'b0}}, 1'b1}, 1'b0, exp_s, 1'b0);
        run_op("full_ripple", ones, '0, 1'b1, '0, 1'b1);

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        a = {{(N-64){1'b0}}, 64'h0123_4567_89AB_CDEF};
        b = {{(N-64){1'b0}}, 64'h1111_1111_1111_1111};
        c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_s = {{(N-64){1'b0}}, 64'h1234_5678_9ABC_DF00};
        repeat (CHUNKS) @(posedge clk);
        #1;
        chk_bit("bp_out_valid_rise", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = {$urandom, $urandom};
            b = ~a;
            chk_bit("bp_out_valid_hold", out_valid, 1'b1);
            chk_bit("bp_in_ready_low", in_ready, 1'b0);
            chk_vec("bp_sum_hold", s, exp_s);
        end
        $display("[TB] op backpressure s[63:0]=%h c_out=%b", s[63:0], c_out);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_bit("bp_released", out_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_bit("bp_nothing_accepted", busy, 1'b0);

        // Reset in the middle of a run discards the operation.
        @(negedge clk);
        a = ones; b = ones; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_bit("midrun_busy", busy, 1'b1);
        chk_bit("midrun_partial_s_nonzero", (s[31:0] == 32'hFFFF_FFFF), 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("midrun_rst_out_valid", out_valid, 1'b0);
        chk_vec("midrun_rst_s", s, '0);
        chk_bit("midrun_rst_busy", busy, 1'b0);
        chk_bit("midrun_rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("midrun_in_ready_after", in_ready, 1'b1);
        begin
            int seen = 0;
            for (int i = 0; i < CHUNKS + 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk_int("midrun_no_result", seen, 0);
        end
        $display("[TB] op midrun_reset s[63:0]=%h out_valid=%b", s[63:0], out_valid);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
